vga_led_decoder: RTL and testbench



---
 rtl/vga_led_decoder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_vga_led_decoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_led_decoder.sv
// Passive monitor that snoops the seven-segment emulator's VGA stream and decodes eight hex digits per frame.
// Optional frame-timing checker is compiled in with `define DEC_TIMING_CHECK_EN.
module vga_led_decoder #(
    parameter logic [7:0] LIT_THRESH = 8'h80,
    parameter int         HTOTAL_EXP = 1600,
    parameter int         VTOTAL_EXP = 525
) (
    input  logic        clk50,
    input  logic        reset_n,
    input  logic        VGA_CLK,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_BLANK_n,
    input  logic [7:0]  VGA_R,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic [7:0]  decode_err,
    output logic        timing_err
);

    // Handshake: data_valid is a single-cycle strobe with no ready; data_out,
    // decode_err and timing_err change only in that cycle and hold otherwise.

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_capture;

    logic        r_clk, r_clk_d;
    logic        r_hs, r_hs_d;
    logic        r_vs, r_vs_d;
    logic        r_blank, r_blank_d;
    logic [7:0]  r_red;

    logic        w_strobe, w_vs_fall, w_hs_fall;
    logic        w_blank_rise, w_blank_fall;

    logic [9:0]  r_x;
    logic [9:0]  w_x;
    logic [8:0]  r_y;

    logic        w_in_area;
    logic [2:0]  w_digit;
    logic [5:0]  w_px;
    logic [6:0]  w_py;
    logic        w_seg_hit;
    logic [2:0]  w_seg_idx;
    logic [5:0]  w_acc_idx;
    logic        w_sample;
    logic        w_lit;

    logic [55:0] r_acc;
    logic [31:0] w_word;
    logic [7:0]  w_err;
    logic [4:0]  w_dec;
    logic        w_terr_frame;

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_clk     <= 1'b0;
            r_clk_d   <= 1'b0;
            r_hs      <= 1'b0;
            r_hs_d    <= 1'b0;
            r_vs      <= 1'b0;
            r_vs_d    <= 1'b0;
            r_blank   <= 1'b0;
            r_blank_d <= 1'b0;
            r_red     <= 8'h00;
        end else begin
            r_clk     <= VGA_CLK;
            r_clk_d   <= r_clk;
            r_hs      <= VGA_HS;
            r_hs_d    <= r_hs;
            r_vs      <= VGA_VS;
            r_vs_d    <= r_vs;
            r_blank   <= VGA_BLANK_n;
            r_blank_d <= r_blank;
            r_red     <= VGA_R;
        end
    end

    assign w_strobe     = r_clk & ~r_clk_d & r_blank;
    assign w_vs_fall    = r_vs_d & ~r_vs;
    assign w_hs_fall    = r_hs_d & ~r_hs;
    assign w_blank_rise = r_blank & ~r_blank_d;
    assign w_blank_fall = ~r_blank & r_blank_d;

    // A strobe coinciding with the blank rise must already see x = 0.
    assign w_x = w_blank_rise ? 10'd0 : r_x;

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_x <= 10'd0;
            r_y <= 9'd0;
        end else begin
            if (w_strobe) begin
                r_x <= w_x + 10'd1;
            end else if (w_blank_rise) begin
                r_x <= 10'd0;
            end
            if (w_vs_fall) begin
                r_y <= 9'd0;
            end else if (w_blank_fall && (r_y != 9'd511)) begin
                r_y <= r_y + 9'd1;
            end
        end
    end

    // Within 64..575 / 128..255 the offsets reduce to plain bit fields of x and y.
    assign w_in_area = (w_x >= 10'd64) && (w_x <= 10'd575) && (r_y[8:7] == 2'b01);
    assign w_digit   = 3'(w_x[9:6] - 4'd1);
    assign w_px      = w_x[5:0];
    assign w_py      = r_y[6:0];

    always_comb begin
        w_seg_hit = 1'b1;
        w_seg_idx = 3'd0;
        case ({w_px, w_py})
            {6'd20, 7'd4}:   w_seg_idx = 3'd0;
            {6'd44, 7'd28}:  w_seg_idx = 3'd1;
            {6'd44, 7'd76}:  w_seg_idx = 3'd2;
            {6'd20, 7'd100}: w_seg_idx = 3'd3;
            {6'd4,  7'd76}:  w_seg_idx = 3'd4;
            {6'd4,  7'd28}:  w_seg_idx = 3'd5;
            {6'd20, 7'd52}:  w_seg_idx = 3'd6;
            default:         w_seg_hit = 1'b0;
        endcase
    end

    assign w_acc_idx = ({3'b000, w_digit} * 6'd7) + {3'b000, w_seg_idx};
    assign w_sample  = w_strobe & ~w_vs_fall & w_in_area & w_seg_hit;
    assign w_lit     = (r_red >= LIT_THRESH);

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= 56'd0;
        end else if (w_vs_fall) begin
            r_acc <= 56'd0;
        end else if (w_sample) begin
            r_acc[w_acc_idx] <= w_lit;
        end
    end

    // Returns {illegal, nibble}; segment order {g,f,e,d,c,b,a}.
    function automatic logic [4:0] glyph_to_nibble(input logic [6:0] g);
        case (g)
            7'h3F:   return 5'h00;
            7'h06:   return 5'h01;
            7'h5B:   return 5'h02;
            7'h4F:   return 5'h03;
            7'h66:   return 5'h04;
            7'h6D:   return 5'h05;
            7'h7D:   return 5'h06;
            7'h07:   return 5'h07;
            7'h7F:   return 5'h08;
            7'h67:   return 5'h09;
            7'h77:   return 5'h0A;
            7'h7C:   return 5'h0B;
            7'h39:   return 5'h0C;
            7'h5E:   return 5'h0D;
            7'h79:   return 5'h0E;
            7'h71:   return 5'h0F;
            default: return 5'h10;
        endcase
    endfunction

    always_comb begin
        w_word = 32'd0;
        w_err  = 8'd0;
        w_dec  = 5'd0;
        for (int d = 0; d < 8; d++) begin
            w_dec                 = glyph_to_nibble(r_acc[d*7 +: 7]);
            w_word[31-4*d -: 4]   = w_dec[3:0];
            w_err[7-d]            = w_dec[4];
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == ST_IDLE) && w_vs_fall) begin
            w_state_nxt = ST_CAPTURE;
        end
    end

    // The first VS fall after reset closes a partial frame, so only CAPTURE reports.
    always_comb begin
        w_capture = (r_state == ST_CAPTURE) && w_vs_fall;
    end

`ifdef DEC_TIMING_CHECK_EN
    logic [11:0] r_hcnt;
    logic [9:0]  r_vcnt;
    logic        r_h_armed;
    logic        r_terr;
    logic        w_h_bad;
    logic        w_v_bad;

    assign w_h_bad      = w_hs_fall & r_h_armed & (r_hcnt != 12'(HTOTAL_EXP));
    assign w_v_bad      = w_vs_fall & (r_vcnt != 10'(VTOTAL_EXP));
    assign w_terr_frame = r_terr | w_h_bad | w_v_bad;

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_hcnt    <= 12'd0;
            r_vcnt    <= 10'd0;
            r_h_armed <= 1'b0;
            r_terr    <= 1'b0;
        end else begin
            if (w_hs_fall) begin
                r_hcnt <= 12'd1;
            end else if (r_hcnt != 12'hFFF) begin
                r_hcnt <= r_hcnt + 12'd1;
            end
            if (w_vs_fall) begin
                r_vcnt <= w_hs_fall ? 10'd1 : 10'd0;
            end else if (w_hs_fall && (r_vcnt != 10'h3FF)) begin
                r_vcnt <= r_vcnt + 10'd1;
            end
            // The line in progress when CAPTURE starts has no trusted start edge.
            if (r_state == ST_IDLE) begin
                r_h_armed <= 1'b0;
            end else if (w_hs_fall) begin
                r_h_armed <= 1'b1;
            end
            if (w_vs_fall) begin
                r_terr <= 1'b0;
            end else if (w_h_bad) begin
                r_terr <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timing;
    assign w_unused_timing = ^{12'(HTOTAL_EXP), 10'(VTOTAL_EXP), w_hs_fall};
    assign w_terr_frame    = 1'b0;
`endif

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            data_out   <= 32'd0;
            data_valid <= 1'b0;
            decode_err <= 8'd0;
            timing_err <= 1'b0;
        end else begin
            data_valid <= w_capture;
            if (w_capture) begin
                data_out   <= w_word;
                decode_err <= w_err;
                timing_err <= w_terr_frame;
            end
        end
    end

endmodule

// File: tb/tb_vga_led_decoder.sv
// Directed bench for vga_led_decoder: draws compressed frames (only the sampled rows carry full pixel lines).
// Build with +define+DEC_TIMING_CHECK_EN to add the line-timing scenario.
module tb_vga_led_decoder;

`ifdef DEC_TIMING_CHECK_EN
  localparam int   H_T   = 32;
  localparam int   V_T   = 20;
  localparam logic EXP_T = 1'b1;  // display frames carry no HS edges
`else
  localparam int   H_T   = 1600;
  localparam int   V_T   = 525;
  localparam logic EXP_T = 1'b0;
`endif

  logic        clk50 = 1'b0;
  logic        reset_n;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n;
  logic [7:0]  VGA_R;
  logic [31:0] data_out;
  logic        data_valid;
  logic [7:0]  decode_err;
  logic        timing_err;

  int checks   = 0;
  int failures = 0;

  always #10 clk50 = ~clk50;

  vga_led_decoder #(
    .LIT_THRESH (8'h80),
    .HTOTAL_EXP (H_T),
    .VTOTAL_EXP (V_T)
  ) dut (
    .clk50       (clk50),
    .reset_n     (reset_n),
    .VGA_CLK     (VGA_CLK),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_n (VGA_BLANK_n),
    .VGA_R       (VGA_R),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .decode_err  (decode_err),
    .timing_err  (timing_err)
  );

  function automatic logic [6:0] enc7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h67;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [55:0] enc_word(input logic [31:0] v);
    logic [55:0] g;
    g = '0;
    for (int d = 0; d < 8; d++) g[d*7 +: 7] = enc7(v[31-4*d -: 4]);
    return g;
  endfunction

  // Screen model: each segment is a filled bar inside the 64x128 digit cell.
  function automatic logic [7:0] red_at(input logic [6:0] g, input int px, input int py,
                                        input logic [7:0] lit, input logic [7:0] unlit);
    int s;
    s = -1;
    if (px >= 8 && px <= 35 && py >= 2 && py <= 6)        s = 0;
    else if (px >= 42 && px <= 46 && py >= 8 && py <= 48)  s = 1;
    else if (px >= 42 && px <= 46 && py >= 56 && py <= 96) s = 2;
    else if (px >= 8 && px <= 35 && py >= 98 && py <= 102) s = 3;
    else if (px >= 2 && px <= 6 && py >= 56 && py <= 96)   s = 4;
    else if (px >= 2 && px <= 6 && py >= 8 && py <= 48)    s = 5;
    else if (px >= 8 && px <= 35 && py >= 50 && py <= 54)  s = 6;
    if (s < 0) return 8'h00;
    return g[s] ? lit : unlit;
  endfunction

  // ---------------- driver tasks (inputs change on the falling edge) ----------------
  task automatic vid_line(input logic [55:0] glyphs, input int y,
                          input logic [7:0] lit, input logic [7:0] unlit);
    int py;
    py = y - 128;
    if (y >= 128 && y <= 255 && (py == 4 || py == 28 || py == 52 || py == 76 || py == 100)) begin
      for (int i = 0; i < 576; i++) begin
        logic [7:0] r;
        r = 8'h00;
        if (i >= 64) r = red_at(glyphs[((i-64)/64)*7 +: 7], (i-64)%64, py, lit, unlit);
        @(negedge clk50);
        VGA_BLANK_n = 1'b1;
        VGA_CLK     = 1'b0;
        VGA_R       = r;
        @(negedge clk50);
        VGA_CLK     = 1'b1;
      end
      @(negedge clk50);
      VGA_CLK     = 1'b0;
      VGA_BLANK_n = 1'b0;
      VGA_R       = 8'h00;
      @(negedge clk50);
    end else begin
      @(negedge clk50);
      VGA_BLANK_n = 1'b1;
      @(negedge clk50);
      VGA_BLANK_n = 1'b0;
    end
  endtask

  task automatic draw_frame(input logic [55:0] g_top, input logic [55:0] g_bot, input int split_py,
                            input logic [7:0] lit, input logic [7:0] unlit, input int y_lo, input int y_hi);
    for (int y = y_lo; y <= y_hi; y++)
      vid_line(((y - 128) < split_py) ? g_top : g_bot, y, lit, unlit);
  endtask

  task automatic vsync(output int pulses, output int lat, output logic [31:0] d,
                       output logic [7:0] e, output logic t);
    pulses = 0; lat = -1; d = '0; e = '0; t = 1'b0;
    @(negedge clk50);
    VGA_VS = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk50);
      if (data_valid === 1'b1) begin
        pulses++;
        if (lat < 0) lat = k;
        d = data_out; e = decode_err; t = timing_err;
      end
      if (k == 3) VGA_VS = 1'b1;
    end
  endtask

  task automatic timing_frame(input int bad_line, output int pulses, output logic terr);
    pulses = 0; terr = 1'b0;
    for (int l = 0; l < V_T; l++) begin
      int len;
      len = (l == bad_line) ? H_T + 2 : H_T;
      for (int c = 0; c < len; c++) begin
        @(negedge clk50);
        if (data_valid === 1'b1) begin
          pulses++;
          terr = timing_err;
        end
        VGA_HS = (c < 4) ? 1'b0 : 1'b1;
        VGA_VS = (l == 0 && c >= 8 && c < 12) ? 1'b0 : 1'b1;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    VGA_CLK = 1'b0; VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK_n = 1'b0; VGA_R = 8'h00;
    repeat (3) @(negedge clk50);
    checks++; if (data_out !== 32'd0) begin failures++; $display("FAIL reset_data_out got=%h exp=%h", data_out, 32'd0); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    checks++; if (decode_err !== 8'd0) begin failures++; $display("FAIL reset_decode_err got=%h exp=00", decode_err); end
    checks++; if (timing_err !== 1'b0) begin failures++; $display("FAIL reset_timing_err got=%b exp=0", timing_err); end
    reset_n = 1'b1;
    repeat (4) @(negedge clk50);
  endtask

  task automatic test_basic_frames();
    logic [55:0] g;
    int p, lat; logic [31:0] d; logic [7:0] e; logic t;
    g = enc_word(32'h12345678);
    vsync(p, lat, d, e, t);
    checks++; if (p !== 0) begin failures++; $display("FAIL first_vs_pulses got=%0d exp=0", p); end
    for (int f = 0; f < 2; f++) begin
      draw_frame(g, g, 128, 8'hFF, 8'h20, 0, 255);
      vsync(p, lat, d, e, t);
      checks++; if (p !== 1) begin failures++; $display("FAIL basic_pulses f%0d got=%0d exp=1", f, p); end
      checks++; if (lat !== 2) begin failures++; $display("FAIL basic_latency f%0d got=%0d exp=2", f, lat); end
      checks++; if (d !== 32'h12345678) begin failures++; $display("FAIL basic_data f%0d got=%h exp=12345678", f, d); end
      checks++; if (e !== 8'h00) begin failures++; $display("FAIL basic_err f%0d got=%h exp=00", f, e); end
      checks++; if (t !== EXP_T) begin failures++; $display("FAIL basic_timing f%0d got=%b exp=%b", f, t, EXP_T); end
    end
    repeat (5) @(negedge clk50);
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL hold_valid got=%b exp=0", data_valid); end
    checks++; if (data_out !== 32'h12345678) begin failures++; $display("FAIL hold_data got=%h exp=12345678", data_out); end
  endtask

  task automatic test_pattern_change();
    logic [55:0] g_old, g_new;
    int p, lat; logic [31:0] d; logic [7:0] e; logic t;
    g_old = enc_word(32'hDEADBEEF);
    g_new = enc_word(32'h0000000F);
    draw_frame(g_old, g_old, 128, 8'hFF, 8'h20, 0, 255);
    vsync(p, lat, d, e, t);
    checks++; if (p !== 1 || d !== 32'hDEADBEEF) begin failures++; $display("FAIL change_old got=%h pulses=%0d exp=deadbeef", d, p); end
    // Switch after row 52: a,b,f,g come from the old word, c,d,e from the new one.
    draw_frame(g_old, g_new, 60, 8'hFF, 8'h20, 0, 255);
    vsync(p, lat, d, e, t);
    checks++; if (p !== 1 || d !== 32'hD68DB66F) begin failures++; $display("FAIL change_mix got=%h pulses=%0d exp=d68db66f", d, p); end
    checks++; if (e !== 8'h00) begin failures++; $display("FAIL change_mix_err got=%h exp=00", e); end
    draw_frame(g_new, g_new, 128, 8'hFF, 8'h20, 0, 255);
    vsync(p, lat, d, e, t);
    checks++; if (p !== 1 || d !== 32'h0000000F) begin failures++; $display("FAIL change_new got=%h pulses=%0d exp=0000000f", d, p); end
  endtask

  task automatic test_decode_err();
    logic [55:0] g;
    int p, lat; logic [31:0] d; logic [7:0] e; logic t;
    g = enc_word(32'h12345678);
    g[3*7 +: 7] = 7'h00;
    draw_frame(g, g, 128, 8'hFF, 8'h20, 0, 255);
    vsync(p, lat, d, e, t);
    checks++; if (p !== 1 || d !== 32'h12305678) begin failures++; $display("FAIL decode_err_data got=%h pulses=%0d exp=12305678", d, p); end
    checks++; if (e !== 8'b0001_0000) begin failures++; $display("FAIL decode_err_flags got=%b exp=00010000", e); end
  endtask

  task automatic test_threshold();
    logic [55:0] g;
    int p, lat; logic [31:0] d; logic [7:0] e; logic t;
    g = enc_word(32'h89ABCDEF);
    draw_frame(g, g, 128, 8'h80, 8'h7F, 0, 255);
    vsync(p, lat, d, e, t);
    checks++; if (p !== 1 || d !== 32'h89ABCDEF) begin failures++; $display("FAIL thresh_data got=%h pulses=%0d exp=89abcdef", d, p); end
    checks++; if (e !== 8'h00) begin failures++; $display("FAIL thresh_err got=%h exp=00", e); end
  endtask

  task automatic test_reset_mid_frame();
    logic [55:0] g;
    int p, lat; logic [31:0] d; logic [7:0] e; logic t;
    g = enc_word(32'h0F0F0F0F);
    draw_frame(g, g, 128, 8'hFF, 8'h20, 0, 140);
    @(negedge clk50);
    reset_n = 1'b0;
    #1;
    checks++; if (data_out !== 32'd0) begin failures++; $display("FAIL midreset_data got=%h exp=00000000", data_out); end
    checks++; if (decode_err !== 8'd0 || data_valid !== 1'b0 || timing_err !== 1'b0) begin
      failures++; $display("FAIL midreset_flags err=%h valid=%b terr=%b exp=0", decode_err, data_valid, timing_err); end
    @(negedge clk50);
    reset_n = 1'b1;
    draw_frame(g, g, 128, 8'hFF, 8'h20, 141, 255);
    vsync(p, lat, d, e, t);
    checks++; if (p !== 0) begin failures++; $display("FAIL midreset_first_vs got=%0d pulses exp=0", p); end
    draw_frame(g, g, 128, 8'hFF, 8'h20, 0, 255);
    vsync(p, lat, d, e, t);
    checks++; if (p !== 1 || d !== 32'h0F0F0F0F) begin failures++; $display("FAIL midreset_recover got=%h pulses=%0d exp=0f0f0f0f", d, p); end
    checks++; if (t !== EXP_T) begin failures++; $display("FAIL midreset_timing got=%b exp=%b", t, EXP_T); end
  endtask

  task automatic test_signal_loss();
    int seen;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk50);
      if (data_valid === 1'b1) seen++;
      VGA_BLANK_n = (i % 8) < 4;
    end
    VGA_BLANK_n = 1'b0;
    checks++; if (seen !== 0) begin failures++; $display("FAIL loss_pulses got=%0d exp=0", seen); end
    checks++; if (data_out !== 32'h0F0F0F0F) begin failures++; $display("FAIL loss_hold got=%h exp=0f0f0f0f", data_out); end
  endtask

`ifdef DEC_TIMING_CHECK_EN
  task automatic test_timing();
    int p; logic t;
    @(negedge clk50);
    reset_n = 1'b0;
    @(negedge clk50);
    reset_n = 1'b1;
    repeat (4) @(negedge clk50);
    timing_frame(-1, p, t);
    checks++; if (p !== 0) begin failures++; $display("FAIL timing_idle got=%0d pulses exp=0", p); end
    timing_frame(5, p, t);
    checks++; if (p !== 1 || t !== 1'b0) begin failures++; $display("FAIL timing_clean got=%b pulses=%0d exp=0", t, p); end
    timing_frame(-1, p, t);
    checks++; if (p !== 1 || t !== 1'b1) begin failures++; $display("FAIL timing_long_line got=%b pulses=%0d exp=1", t, p); end
    timing_frame(-1, p, t);
    checks++; if (p !== 1 || t !== 1'b0) begin failures++; $display("FAIL timing_after got=%b pulses=%0d exp=0", t, p); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frames();
    test_pattern_change();
    test_decode_err();
    test_threshold();
    test_reset_mid_frame();
    test_signal_loss();
`ifdef DEC_TIMING_CHECK_EN
    test_timing();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
